mu0_bus_responder: RTL and testbench

Memory-side responder for the MU0 shared address/data bus: samples read/write requests from the CPU, inserts a fixed number of wait states, then either returns read data with an output-enable for the 16-bit bus tristate driver or commits write data into its internal word array. It is the target end of the CPU's bus, and is paired with the existing tristate driver that places `rdata` on the shared bus when `rdata_oe` is high.

---
 rtl/mu0_bus_pkg.sv | 18 +
 rtl/mu0_bus_responder_if.sv | 24 ++
 rtl/mu0_resp_sram.sv | 43 ++++
 rtl/mu0_bus_responder.sv | 122 ++++++++++++
 tb/tb_mu0_bus_responder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mu0_bus_pkg.sv
// Shared types and widths for the MU0 bus responder slice.
package mu0_bus_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } resp_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } bus_op_t;

endpackage

// File: rtl/mu0_bus_responder_if.sv
// MU0 shared-bus signal bundle; master is the CPU, slave is the memory responder.
interface mu0_bus_responder_if;
    import mu0_bus_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] rdata;
    logic              rdata_oe;
    logic              ready;
    logic              wr_err;

    modport master (
        output addr, wdata, rd, wr,
        input  rdata, rdata_oe, ready, wr_err
    );

    modport slave (
        input  addr, wdata, rd, wr,
        output rdata, rdata_oe, ready, wr_err
    );

endinterface

// File: rtl/mu0_resp_sram.sv
// Single-port MEM_DEPTH x 16 word array with registered read port.
// Out-of-range addresses read as zero and ignore writes; contents survive rst.
module mu0_resp_sram
    import mu0_bus_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign in_range = ({{(32-ADDR_W){1'b0}}, addr} < MEM_DEPTH);
    assign idx      = addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    // q is zero except in the cycle after a read, so it can drive rdata directly
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (re && in_range) begin
            q <= mem[idx];
        end else begin
            q <= '0;
        end
    end

endmodule

// File: rtl/mu0_bus_responder.sv
// Memory-side responder for the MU0 bus: capture, fixed wait states, respond.
// Optional write protection below ROM_TOP via `define MU0_BUS_WRITE_PROTECT_EN.
//
//   state   | meaning
//   IDLE    | waiting for rd/wr; captures addr, wdata and operation
//   WAIT    | counting down wait states, bus inputs ignored
//   RESPOND | ready pulse; read data on bus, or write commits at cycle end
module mu0_bus_responder
    import mu0_bus_pkg::*;
#(
    parameter int unsigned       MEM_DEPTH   = 4096,
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] ROM_TOP     = 12'h000
) (
    input  logic                 clk,
    input  logic                 rst,
    mu0_bus_responder_if.slave   bus
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    resp_state_t       state;
    logic [3:0]        wait_cnt;
    bus_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              oe_q;
    logic              ready_q;
    logic              wr_err_q;

    logic              req;
    bus_op_t           op_new;
    bus_op_t           cur_op;
    logic [ADDR_W-1:0] cur_addr;
    logic              enter_resp;
    logic              prot_hit;
    logic              sram_re;
    logic              sram_we;
    logic [DATA_W-1:0] sram_q;

    assign req    = bus.rd | bus.wr;
    // a simultaneous rd+wr is treated as a read
    assign op_new = bus.rd ? OP_RD : OP_WR;

    // In IDLE the live bus is the transaction; afterwards the captured copy is.
    assign cur_op   = (state == IDLE) ? op_new : op_q;
    assign cur_addr = (state == IDLE) ? bus.addr : addr_q;

    assign enter_resp = ((state == IDLE) && req && (WAIT_CYCLES == 0))
                     || ((state == WAIT) && (wait_cnt == 4'd0));

`ifdef MU0_BUS_WRITE_PROTECT_EN
    assign prot_hit = (cur_op == OP_WR) && (cur_addr < ROM_TOP);
`else
    logic unused_rom_top;
    assign unused_rom_top = ^ROM_TOP;
    assign prot_hit       = 1'b0;
`endif

    // wr_err_q doubles as the "write rejected" flag during RESPOND
    assign sram_re = enter_resp && (cur_op == OP_RD) && !rst;
    assign sram_we = (state == RESPOND) && (op_q == OP_WR) && !wr_err_q && !rst;

    mu0_resp_sram #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_sram (
        .clk   (clk),
        .rst   (rst),
        .re    (sram_re),
        .we    (sram_we),
        .addr  (cur_addr),
        .wdata (wdata_q),
        .q     (sram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            op_q     <= OP_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
            oe_q     <= 1'b0;
            ready_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            ready_q  <= enter_resp;
            oe_q     <= enter_resp && (cur_op == OP_RD);
            wr_err_q <= enter_resp && prot_hit;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q     <= op_new;
                        addr_q   <= bus.addr;
                        wdata_q  <= bus.wdata;
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_CYCLES == 0) ? RESPOND : WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdata    = sram_q;
    assign bus.rdata_oe = oe_q;
    assign bus.ready    = ready_q;
    assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_mu0_bus_responder.sv
// Self-checking bench for mu0_bus_responder: one DUT with one wait state, one with none.
// Protection expectations follow `define MU0_BUS_WRITE_PROTECT_EN.
module tb_mu0_bus_responder;
    import mu0_bus_pkg::*;

    typedef struct {
        bit          r;
        bit          w;
        logic [11:0] a;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        bit          exp_err;
        bit          chk_ne;
    } vec_t;

    typedef struct packed {
        logic [15:0] rdata;
        logic        oe;
        logic        ready;
        logic        err;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mu0_bus_responder_if bus1 ();
    mu0_bus_responder_if bus0 ();

    mu0_bus_responder #(
        .MEM_DEPTH   (4096),
        .WAIT_CYCLES (1),
        .ROM_TOP     (12'h100)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    mu0_bus_responder #(
        .MEM_DEPTH   (64),
        .WAIT_CYCLES (0),
        .ROM_TOP     (12'h000)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_ne(input string nm, input logic [31:0] act, input logic [31:0] bad);
        total_cnt++;
        if (act !== bad) pass_cnt++;
        else $display("FAIL %s: got %h expected anything but %h", nm, act, bad);
    endtask

    task automatic set_req(input int d, input bit r, input bit w,
                           input logic [11:0] a, input logic [15:0] wd);
        if (d == 1) begin
            bus1.rd = r; bus1.wr = w; bus1.addr = a; bus1.wdata = wd;
        end else begin
            bus0.rd = r; bus0.wr = w; bus0.addr = a; bus0.wdata = wd;
        end
    endtask

    function automatic obs_t obs(input int d);
        if (d == 1) return {bus1.rdata, bus1.rdata_oe, bus1.ready, bus1.wr_err};
        return {bus0.rdata, bus0.rdata_oe, bus0.ready, bus0.wr_err};
    endfunction

    task automatic chk_idle(input int d, input string nm);
        obs_t o;
        o = obs(d);
        chk({nm, "_rdata"}, 32'(o.rdata), 32'h0);
        chk({nm, "_oe"},    32'(o.oe),    32'h0);
        chk({nm, "_ready"}, 32'(o.ready), 32'h0);
        chk({nm, "_err"},   32'(o.err),   32'h0);
    endtask

    // Called at a negedge; returns at a negedge with the responder back in IDLE.
    task automatic txn(input int d, input bit r, input bit w, input logic [11:0] a,
                       input logic [15:0] wd, input logic [15:0] exp_rd,
                       input bit exp_err, input bit ne, input string nm);
        int   lat;
        obs_t o;
        lat = (d == 1) ? 1 : 0;
        set_req(d, r, w, a, wd);
        @(posedge clk);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            o = obs(d);
            chk({nm, "_early_ready"}, 32'(o.ready), 32'h0);
            @(posedge clk);
        end
        @(negedge clk);
        o = obs(d);
        chk({nm, "_ready"}, 32'(o.ready), 32'h1);
        chk({nm, "_oe"},    32'(o.oe),    32'(r));
        if (ne) chk_ne({nm, "_rdata"}, 32'(o.rdata), 32'(exp_rd));
        else    chk({nm, "_rdata"}, 32'(o.rdata), r ? 32'(exp_rd) : 32'h0);
        chk({nm, "_err"},   32'(o.err),   32'(exp_err));
        set_req(d, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        o = obs(d);
        chk({nm, "_after_ready"}, 32'(o.ready), 32'h0);
        chk({nm, "_after_oe"},    32'(o.oe),    32'h0);
        chk({nm, "_after_rdata"}, 32'(o.rdata), 32'h0);
    endtask

    vec_t vt[11];
    obs_t o;

    initial begin
        vt[0]  = '{1'b0, 1'b1, 12'h010, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 12'h010, 16'h0000, 16'hBEEF, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 12'h020, 16'h5A5A, 16'h0000, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 12'h020, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 12'h020, 16'h0000, 16'h5A5A, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 12'h030, 16'hAAAA, 16'h0000, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 12'h030, 16'h0000, 16'hAAAA, 1'b0, 1'b0};
`ifdef MU0_BUS_WRITE_PROTECT_EN
        vt[7]  = '{1'b0, 1'b1, 12'h0FF, 16'hC0DE, 16'h0000, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 12'h0FF, 16'h0000, 16'hC0DE, 1'b0, 1'b1};
`else
        vt[7]  = '{1'b0, 1'b1, 12'h0FF, 16'hC0DE, 16'h0000, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 12'h0FF, 16'h0000, 16'hC0DE, 1'b0, 1'b0};
`endif
        vt[9]  = '{1'b0, 1'b1, 12'h100, 16'h1357, 16'h0000, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b0, 12'h100, 16'h0000, 16'h1357, 1'b0, 1'b0};

        set_req(1, 1'b0, 1'b0, 12'h000, 16'h0000);
        set_req(0, 1'b0, 1'b0, 12'h000, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle(1, "rst_held_d1");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle(1, $sformatf("idle%0d_d1", i));
            chk_idle(0, $sformatf("idle%0d_d0", i));
        end

        for (int i = 0; i < 11; i++) begin
            txn(1, vt[i].r, vt[i].w, vt[i].a, vt[i].wd, vt[i].exp_rd,
                vt[i].exp_err, vt[i].chk_ne, $sformatf("vec%0d", i));
        end

        // reset during WAIT of a write: no commit
        set_req(1, 1'b0, 1'b1, 12'h030, 16'h1234);
        @(posedge clk);
        @(negedge clk);
        chk("rstwait_ready_before", 32'(bus1.ready), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle(1, "rstwait_out");
        rst = 1'b0;
        set_req(1, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        chk_idle(1, "rstwait_idle");
        txn(1, 1'b1, 1'b0, 12'h030, 16'h0000, 16'hAAAA, 1'b0, 1'b0, "rstwait_readback");

        // zero-wait DUT: preload, then back-to-back reads
        txn(0, 1'b0, 1'b1, 12'h000, 16'h1111, 16'h0000, 1'b0, 1'b0, "z_wr0");
        txn(0, 1'b0, 1'b1, 12'h001, 16'h2222, 16'h0000, 1'b0, 1'b0, "z_wr1");
        txn(0, 1'b1, 1'b0, 12'h000, 16'h0000, 16'h1111, 1'b0, 1'b0, "z_rd0");
        txn(0, 1'b1, 1'b0, 12'h001, 16'h0000, 16'h2222, 1'b0, 1'b0, "z_rd1");

        // out-of-range (depth 64): dropped write, zero read, no aliasing onto 0x001
        txn(0, 1'b0, 1'b1, 12'h041, 16'hDEAD, 16'h0000, 1'b0, 1'b0, "oor_wr");
        txn(0, 1'b1, 1'b0, 12'h041, 16'h0000, 16'h0000, 1'b0, 1'b0, "oor_rd");
        txn(0, 1'b1, 1'b0, 12'h001, 16'h0000, 16'h2222, 1'b0, 1'b0, "oor_alias");

        // reset coinciding with the RESPOND edge of a write: no commit
        txn(0, 1'b0, 1'b1, 12'h005, 16'h7777, 16'h0000, 1'b0, 1'b0, "rr_pre");
        set_req(0, 1'b0, 1'b1, 12'h005, 16'h8888);
        @(posedge clk);
        @(negedge clk);
        chk("rr_ready", 32'(bus0.ready), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle(0, "rr_out");
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        txn(0, 1'b1, 1'b0, 12'h005, 16'h0000, 16'h7777, 1'b0, 1'b0, "rr_readback");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
